// File: rtl/wishbone_pkg.sv
// Shared definitions for the classic-Wishbone arbiter: FSM encoding and
// the sizing helper for the stall/timeout counter.
package wishbone_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWNED = 2'd1,
    ERR   = 2'd2
  } arbState_e;

  // A timeout of 0 still needs a 1-bit counter so the declaration stays legal.
  function automatic int cntWidth(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches from ptr_i+1 upward (wrapping)
// and returns the first requester as a one-hot vector plus its index.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o
);

  logic          found;
  logic [PW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= N; i++) begin
      cand = PW'((int'(ptr_i) + i) % N);
      if (!found && req_i[cand]) begin
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wishbone_arbiter.sv
// N-master to 1-slave classic Wishbone arbiter with round-robin ownership,
// block-transfer hold and a stalled-slave timeout that reports m_err.
module wishbone_arbiter
  import wishbone_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADR_WIDTH   = 8,
  parameter int DAT_WIDTH   = 8,
  parameter int SEL_WIDTH   = DAT_WIDTH / 8,
  parameter int TIMEOUT     = 255
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_MASTERS*ADR_WIDTH-1:0] m_adr,
  input  logic [NUM_MASTERS*DAT_WIDTH-1:0] m_datwr,
  input  logic [NUM_MASTERS*SEL_WIDTH-1:0] m_sel,
  input  logic [NUM_MASTERS-1:0]           m_we,
  input  logic [NUM_MASTERS-1:0]           m_stb,
  input  logic [NUM_MASTERS-1:0]           m_cyc,
  output logic [NUM_MASTERS*DAT_WIDTH-1:0] m_datrd,
  output logic [NUM_MASTERS-1:0]           m_ack,
  output logic [NUM_MASTERS-1:0]           m_err,
  output logic [ADR_WIDTH-1:0]             s_adr,
  output logic [DAT_WIDTH-1:0]             s_datwr,
  output logic [SEL_WIDTH-1:0]             s_sel,
  output logic                             s_we,
  output logic                             s_stb,
  output logic                             s_cyc,
  input  logic [DAT_WIDTH-1:0]             s_datrd,
  input  logic                             s_ack,
  output logic [NUM_MASTERS-1:0]           grant,
  output logic                             timeout_evt
);

  localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = cntWidth(TIMEOUT);

  arbState_e            state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [PW-1:0]        owner_q, owner_d;
  logic [PW-1:0]        lastOwner_q, lastOwner_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NUM_MASTERS-1:0] winGnt;
  logic [PW-1:0]        winIdx;
  logic                 owned;
  logic                 inErr;

  // Only m_cyc competes; a bare m_stb never wins the bus.
  rr_arbiter #(
    .N  (NUM_MASTERS),
    .PW (PW)
  ) u_rr (
    .req_i (m_cyc),
    .ptr_i (lastOwner_q),
    .gnt_o (winGnt),
    .idx_o (winIdx)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    lastOwner_d = lastOwner_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (|m_cyc) begin
          state_d = OWNED;
          grant_d = winGnt;
          owner_d = winIdx;
        end
      end
      OWNED: begin
        if (!m_cyc[owner_q]) begin
          state_d     = IDLE;
          grant_d     = '0;
          lastOwner_d = owner_q;
          cnt_d       = '0;
        end else if (s_stb && !s_ack) begin
          // An ack in the would-be timeout cycle takes the other branch and wins.
          if ((TIMEOUT > 0) && ((int'(cnt_q) + 1) == TIMEOUT)) begin
            state_d = ERR;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (s_ack) begin
          cnt_d = '0;
        end
      end
      ERR: begin
        state_d = OWNED;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      owner_q     <= '0;
      lastOwner_q <= PW'(NUM_MASTERS - 1);
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      lastOwner_q <= lastOwner_d;
      cnt_q       <= cnt_d;
    end
  end

  // Gating with rst drops ownership in the very cycle reset is raised.
  assign owned = (state_q == OWNED) && !rst;
  assign inErr = (state_q == ERR) && !rst;

  assign s_adr       = m_adr[int'(owner_q)*ADR_WIDTH +: ADR_WIDTH];
  assign s_datwr     = m_datwr[int'(owner_q)*DAT_WIDTH +: DAT_WIDTH];
  assign s_sel       = m_sel[int'(owner_q)*SEL_WIDTH +: SEL_WIDTH];
  assign s_we        = owned && m_we[owner_q];
  assign s_cyc       = owned && m_cyc[owner_q];
  assign s_stb       = owned && m_cyc[owner_q] && m_stb[owner_q];
  assign m_datrd     = {NUM_MASTERS{s_datrd}};
  assign m_ack       = (owned && s_ack) ? grant_q : '0;
  assign m_err       = inErr ? grant_q : '0;
  assign timeout_evt = inErr;
  assign grant       = rst ? '0 : grant_q;

endmodule
